// File: rtl/burst_arb_pkg.sv
// Shared types for the burst-limited round-robin arbiter: FSM state,
// requester index and the default requester count.
package burst_arb_pkg;

  localparam int N_REQ_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  typedef logic [1:0] req_idx_t;

endpackage

// File: rtl/burst_rr_arbiter_rr_pick.sv
// Rotating-priority picker: finds the first set request bit at or after ptr,
// wrapping modulo 4.
module rr_pick
  import burst_arb_pkg::*;
(
  input  logic [3:0] req,
  input  req_idx_t   ptr,
  output logic       found,
  output req_idx_t   idx
);

  always_comb begin
    req_idx_t cand;
    cand  = ptr;
    found = 1'b0;
    idx   = ptr;
    // Walk from the farthest offset down so the nearest requester wins last.
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + req_idx_t'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/burst_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and optional burst limit,
// enabled by defining BURST_RR_ARBITER_BURST_LIMIT_EN.
module burst_rr_arbiter
  import burst_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int MAX_BURST = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       gnt_id,
  output logic             busy,
  output logic             preempt
);

  if (N_REQ != 4 || MAX_BURST < 2 || MAX_BURST > 256) begin : g_param_check
    $error("burst_rr_arbiter: unsupported N_REQ or MAX_BURST");
  end

  arb_state_e       state_q;
  logic [N_REQ-1:0] gnt_q;
  req_idx_t         gnt_id_q;
  req_idx_t         ptr_q;
  logic             busy_q;
  logic             preempt_q;
  logic             pick_found;
  req_idx_t         pick_idx;

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef BURST_RR_ARBITER_BURST_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  logic [CNT_W-1:0] burst_cnt_q;
  logic [CNT_W-1:0] burst_cnt_d;
  logic             at_limit;

  // Saturating increment keeps the counter from ever wrapping.
  assign at_limit    = (burst_cnt_q == CNT_W'(MAX_BURST));
  assign burst_cnt_d = at_limit ? burst_cnt_q : burst_cnt_q + CNT_W'(1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
      ptr_q     <= '0;
`ifdef BURST_RR_ARBITER_BURST_LIMIT_EN
      burst_cnt_q <= '0;
`endif
    end else begin
      preempt_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q  <= OWNED;
            gnt_q    <= N_REQ'(1) << pick_idx;
            gnt_id_q <= pick_idx;
            busy_q   <= 1'b1;
            ptr_q    <= pick_idx + req_idx_t'(1);
`ifdef BURST_RR_ARBITER_BURST_LIMIT_EN
            burst_cnt_q <= CNT_W'(1);
`endif
          end
        end
        OWNED: begin
          // Release takes precedence over the burst limit: no preempt then.
          if (!req[gnt_id_q]) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
          end
`ifdef BURST_RR_ARBITER_BURST_LIMIT_EN
          else if (at_limit) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b1;
          end else begin
            burst_cnt_q <= burst_cnt_d;
          end
`endif
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Bench for burst_rr_arbiter: cycle scoreboard from a reference model,
// directed scenario tasks and a continuous protocol monitor.
module tb_burst_rr_arbiter;

  localparam int MAXB = 8;
`ifdef BURST_RR_ARBITER_BURST_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       preempt;

  int errors = 0;
  int checks = 0;

  burst_rr_arbiter #(.N_REQ(4), .MAX_BURST(MAXB)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .preempt (preempt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       pre;
  } exp_t;

  exp_t sb_q[$];

  bit m_owned = 1'b0;
  int m_id    = 0;
  int m_ptr   = 0;
  int m_cnt   = 0;

  // Reference model: predicts post-edge outputs from the inputs seen at the edge.
  always @(posedge clk) begin : model
    exp_t e;
    bit   pre;
    bit   hit;
    int   c;
    pre = 1'b0;
    hit = 1'b0;
    if (rst) begin
      m_owned = 1'b0; m_id = 0; m_ptr = 0; m_cnt = 0;
    end else if (!m_owned) begin
      for (int k = 0; k < 4; k++) begin
        c = (m_ptr + k) % 4;
        if (!hit && req[c]) begin
          hit = 1'b1; m_owned = 1'b1; m_id = c; m_ptr = (c + 1) % 4; m_cnt = 1;
        end
      end
    end else if (!req[m_id]) begin
      m_owned = 1'b0;
    end else if (LIMIT && m_cnt == MAXB) begin
      m_owned = 1'b0; pre = 1'b1;
    end else begin
      m_cnt++;
    end
    e.gnt  = m_owned ? (4'b0001 << m_id) : 4'b0000;
    e.id   = 2'(m_id);
    e.busy = m_owned;
    e.pre  = pre;
    sb_q.push_back(e);
  end

  always @(negedge clk) begin : scoreboard
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (gnt !== e.gnt || busy !== e.busy || preempt !== e.pre ||
          (e.busy && gnt_id !== e.id)) begin
        errors++;
        $display("FAIL scoreboard t=%0t got gnt=%b id=%0d busy=%b pre=%b want gnt=%b id=%0d busy=%b pre=%b",
                 $time, gnt, gnt_id, busy, preempt, e.gnt, e.id, e.busy, e.pre);
      end
    end
  end

  logic prev_pre = 1'b0;
  always @(negedge clk) begin : monitor
    checks++;
    if ((gnt & (gnt - 4'd1)) !== 4'b0000 || busy !== (|gnt) || (prev_pre && preempt)) begin
      errors++;
      $display("FAIL monitor t=%0t gnt=%b busy=%b pre=%b prev_pre=%b", $time, gnt, busy, preempt, prev_pre);
    end
    prev_pre = preempt;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    tick();
    tick();
    checks++;
    if (gnt !== 4'b0000 || gnt_id !== 2'd0 || busy !== 1'b0 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got gnt=%b id=%0d busy=%b pre=%b want 0000/0/0/0", gnt, gnt_id, busy, preempt);
    end
  endtask

  task automatic test_first_grant();
    req = 4'b1010;
    rst = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
      errors++;
      $display("FAIL first_grant got gnt=%b id=%0d want 0010/1", gnt, gnt_id);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL release got gnt=%b want 0000", gnt);
    end
    tick();
    req = 4'b1010;
    tick();
    checks++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
      errors++;
      $display("FAIL ptr_after_grant got gnt=%b id=%0d want 1000/3", gnt, gnt_id);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_rotation();
    int order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      tick();
      checks++;
      if (gnt !== (4'b0001 << order[t]) || gnt_id !== 2'(order[t])) begin
        errors++;
        $display("FAIL rotation[%0d] got gnt=%b id=%0d want owner %0d", t, gnt, gnt_id, order[t]);
      end
      tick();
      req = 4'b1111 & ~(4'b0001 << order[t]);
      tick();
      checks++;
      if (gnt !== 4'b0000 || preempt !== 1'b0) begin
        errors++;
        $display("FAIL rotation_gap[%0d] got gnt=%b pre=%b want 0000/0", t, gnt, preempt);
      end
      req = 4'b1111;
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_burst_limit();
    do_reset();
    req = 4'b0100;
`ifdef BURST_RR_ARBITER_BURST_LIMIT_EN
    for (int i = 0; i < MAXB; i++) begin
      tick();
      checks++;
      if (gnt !== 4'b0100 || preempt !== 1'b0) begin
        errors++;
        $display("FAIL burst_hold[%0d] got gnt=%b pre=%b want 0100/0", i, gnt, preempt);
      end
    end
    tick();
    checks++;
    if (gnt !== 4'b0000 || preempt !== 1'b1) begin
      errors++;
      $display("FAIL burst_preempt got gnt=%b pre=%b want 0000/1", gnt, preempt);
    end
    tick();
    checks++;
    if (gnt !== 4'b0100 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL burst_regrant got gnt=%b pre=%b want 0100/0", gnt, preempt);
    end
`else
    for (int i = 0; i < 3 * MAXB; i++) begin
      tick();
      checks++;
      if (gnt !== 4'b0100 || preempt !== 1'b0) begin
        errors++;
        $display("FAIL unlimited_hold[%0d] got gnt=%b pre=%b want 0100/0", i, gnt, preempt);
      end
    end
`endif
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_preempt_pair();
    do_reset();
    req = 4'b0011;
`ifdef BURST_RR_ARBITER_BURST_LIMIT_EN
    for (int i = 0; i < MAXB; i++) begin
      tick();
      checks++;
      if (gnt !== 4'b0001) begin
        errors++;
        $display("FAIL pair_owner0[%0d] got gnt=%b want 0001", i, gnt);
      end
    end
    tick();
    checks++;
    if (gnt !== 4'b0000 || preempt !== 1'b1) begin
      errors++;
      $display("FAIL pair_preempt got gnt=%b pre=%b want 0000/1", gnt, preempt);
    end
    tick();
    checks++;
    if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
      errors++;
      $display("FAIL pair_next got gnt=%b id=%0d want 0010/1", gnt, gnt_id);
    end
`else
    for (int i = 0; i < 3 * MAXB; i++) begin
      tick();
      checks++;
      if (gnt !== 4'b0001) begin
        errors++;
        $display("FAIL pair_hold[%0d] got gnt=%b want 0001", i, gnt);
      end
    end
`endif
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_release_at_limit();
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < MAXB; i++) tick();
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL limit_edge_owner got gnt=%b want 0100", gnt);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL release_at_limit got gnt=%b pre=%b want 0000/0", gnt, preempt);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b1000;
    tick();
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL mid_owner got gnt=%b want 1000", gnt);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got gnt=%b busy=%b pre=%b want 0000/0/0", gnt, busy, preempt);
    end
    rst = 1'b0;
    req = 4'b1111;
    tick();
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL post_reset_priority got gnt=%b id=%0d want 0001/0", gnt, gnt_id);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_grant();
    test_rotation();
    test_burst_limit();
    test_preempt_pair();
    test_release_at_limit();
    test_reset_mid();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/burst_rr_arbiter.md
BURST_RR_ARBITER -- requirements
Module: burst_rr_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (fixed at 4 in this revision).
REQ-002 The block SHALL have parameter MAX_BURST, default 8, giving the maximum consecutive grant cycles per tenure (legal range 2..256).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: a synchronous, active-high reset.
REQ-005 The block SHALL have port req, input, 4 bits: level request per requester, held high for as long as access is wanted.
REQ-006 The block SHALL have port gnt, output, 4 bits: registered one-hot grant, or zero when no grant is active.
REQ-007 The block SHALL have port gnt_id, output, 2 bits: index of the current owner, valid only while busy=1.
REQ-008 The block SHALL have port busy, output, 1 bit: high while any gnt bit is high.
REQ-009 The block SHALL have port preempt, output, 1 bit: one-cycle pulse on the cycle a grant is removed by the burst limit.

Function
REQ-010 The block SHALL implement an FSM with two states: IDLE (no grant) and OWNED (exactly one grant).
REQ-011 In IDLE with req!=0 at edge t, the block SHALL assert gnt at t+1 to the first set req bit searching ptr, ptr+1, ... mod 4.
REQ-012 On grant, the block SHALL set gnt_id to the winner, set ptr to (winner+1) mod 4 and set burst_cnt to 1, then enter OWNED.
REQ-013 In IDLE with req==0, the block SHALL keep gnt=0 and leave ptr unchanged.
REQ-014 In OWNED with req[gnt_id]=0 at an edge, the block SHALL drive gnt=0 on the next cycle, return to IDLE and not pulse preempt.
REQ-015 In OWNED with req[gnt_id]=1, the block SHALL increment burst_cnt every cycle; the counter width SHALL be clog2(MAX_BURST)+1 bits and SHALL never wrap.
REQ-016 Every OWNED-to-IDLE exit SHALL produce at least one cycle of gnt=0 before any new grant, so there is no back-to-back grant overlap.
REQ-017 gnt SHALL never have more than one bit set, and req bits of non-owners SHALL have no effect while the state is OWNED.
REQ-018 Simultaneous release and burst limit SHALL be treated as a release, with preempt=0.
REQ-019 A lone requester that is preempted SHALL be re-granted after the single gap cycle.

Reset
REQ-020 While rst=1 at an edge, the block SHALL set gnt=0, gnt_id=0, busy=0, preempt=0, ptr=0, burst_cnt=0 and state=IDLE.
REQ-021 Reset asserted mid-tenure SHALL drop gnt on the next edge, and no preempt pulse SHALL be generated.
REQ-022 In the first cycle after reset release, the block SHALL give priority to req[0].

Configuration
REQ-023 With macro BURST_RR_ARBITER_BURST_LIMIT_EN defined, when burst_cnt==MAX_BURST and req[gnt_id]=1 at an edge, the block SHALL drive gnt=0 next cycle, pulse preempt for one cycle and return to IDLE.
REQ-024 Without the macro, the block SHALL hold the grant until release, tie preempt to 0 and omit burst_cnt logic.

Structure
REQ-025 A shared package burst_arb_pkg SHALL hold the FSM state typedef (IDLE, OWNED), the N_REQ default and the requester index typedef.
REQ-026 Rotating-priority selection SHALL live in the combinational sub-module rr_pick (inputs req and ptr; outputs found and idx).
REQ-027 Total RTL SHALL be 120-400 lines.

Verification
REQ-028 Reset, then req=4'b1010 held: gnt=4'b0010 at cycle 1, gnt_id=1, ptr=2.
REQ-029 req=4'b1111 with each owner releasing after 2 cycles: grant order 0,1,2,3,0, with one zero-gnt cycle between tenures.
REQ-030 With the macro defined and MAX_BURST=8, req=4'b0100 held: gnt=4'b0100 for 8 cycles, then preempt=1 and gnt=0 for 1 cycle, then re-grant.
REQ-031 With the macro defined, req=4'b0011 held: owner 0 preempted after 8 cycles, next grant goes to 1, not 0.
REQ-032 Reset asserted during OWNED with gnt=4'b1000: gnt=0 next cycle, ptr=0 and preempt stays 0.
REQ-033 A continuous checker SHALL confirm gnt is always one-hot or zero, busy==|gnt, and preempt is never high two cycles in a row.
